// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle 12-bit-instruction MIPS-style core:
// opcode and FSM state enums, plus the instruction field positions.
package mips_mc_pkg;

  typedef enum logic [2:0] {
    OP_LOAD  = 3'b000,
    OP_STORE = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_ADDI  = 3'b100,
    OP_BEQ   = 3'b101,
    OP_JMP   = 3'b110,
    OP_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_IDLE
  } state_e;

  localparam int INSTR_W   = 12;
  localparam int OP_MSB    = 11;
  localparam int OP_LSB    = 9;
  localparam int F1_MSB    = 8;
  localparam int F1_LSB    = 6;
  localparam int F2_MSB    = 5;
  localparam int F2_LSB    = 3;
  localparam int F3_MSB    = 2;
  localparam int F3_LSB    = 0;
  localparam int MADDR_MSB = 3;

  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// Register file: REG_CNT x DATA_W, two asynchronous read ports,
// one synchronous write port, synchronous clear on reset.
module mips_mc_regfile #(
  parameter int DATA_W  = 4,
  parameter int REG_CNT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [$clog2(REG_CNT)-1:0] ra_addr,
  output logic [DATA_W-1:0]          ra_data,
  input  logic [$clog2(REG_CNT)-1:0] rb_addr,
  output logic [DATA_W-1:0]          rb_data,
  input  logic                       we,
  input  logic [$clog2(REG_CNT)-1:0] wa,
  input  logic [DATA_W-1:0]          wd
);

  logic [DATA_W-1:0] regs [REG_CNT];

  // NOTE: this is a flop array, not a RAM macro, so every entry can be cleared
  // in reset; a RAM-backed register file could not offer that.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle core: Fetch/Decode/Execute/Mem/Writeback FSM over the 12-bit ISA.
// Define STEP_MODE_EN to add a `step` input that gates each instruction fetch.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int PC_W    = 3,
  parameter int REG_CNT = 8
) (
  input  logic               clk,
  input  logic               reset,
`ifdef STEP_MODE_EN
  input  logic               step,
`endif
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [3:0]         dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ready,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  alu_out,
  output logic               halted
);

  state_e             state, state_nxt, resume_state;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  mdr;
  opcode_e            op;
  logic [2:0]         f1, f2, f3;
  logic               is_alu;
  logic [2:0]         ra_addr, rb_addr;
  logic [DATA_W-1:0]  ra_data, rb_data, alu_res, rf_wd;
  logic               rf_we, mem_done;
  logic [PC_W-1:0]    pc_inc, br_target;

  assign op     = opcode_e'(ir[OP_MSB:OP_LSB]);
  assign f1     = ir[F1_MSB:F1_LSB];
  assign f2     = ir[F2_MSB:F2_LSB];
  assign f3     = ir[F3_MSB:F3_LSB];
  assign is_alu = is_alu_op(op);

  // Where the FSM goes once an instruction has finished.
`ifdef STEP_MODE_EN
  assign resume_state = step ? S_FETCH : S_IDLE;
`else
  assign resume_state = S_FETCH;
`endif

  // ALU ops read f2/f3; BEQ compares f1/f2; STORE sources f1.
  assign ra_addr = is_alu ? f2 : f1;
  assign rb_addr = ((op == OP_ADD) || (op == OP_SUB)) ? f3 : f2;

  mips_mc_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .ra_addr (ra_addr),
    .ra_data (ra_data),
    .rb_addr (rb_addr),
    .rb_data (rb_data),
    .we      (rf_we),
    .wa      (f1),
    .wd      (rf_wd)
  );

  always_comb begin
    alu_res = ra_data;
    case (op)
      OP_ADD:  alu_res = ra_data + rb_data;
      OP_SUB:  alu_res = ra_data - rb_data;
      OP_ADDI: alu_res = ra_data + DATA_W'(f3);
      default: alu_res = ra_data;
    endcase
  end

  assign pc_inc    = pc + PC_W'(1);
  assign br_target = pc_inc + PC_W'($signed(f3));
  assign mem_done  = (state == S_MEM) && dmem_ready;
  assign rf_we     = (state == S_WB);
  assign rf_wd     = (op == OP_LOAD) ? mdr : alu_out;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // NOTE: defaults are assigned first so every path drives state_nxt; a
  // missing branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_BEQ, OP_JMP:    state_nxt = resume_state;
          OP_HALT:           state_nxt = S_HALT;
          default:           state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_done) state_nxt = (op == OP_LOAD) ? S_WB : resume_state;
      end
      S_WB:     state_nxt = resume_state;
      S_HALT:   state_nxt = S_HALT;
      S_IDLE:   state_nxt = resume_state;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values,
  // which is what gives same-register instructions their read-before-write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      mdr     <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        S_DECODE: ir <= imem_rdata;
        S_EXEC: begin
          if (is_alu)         alu_out <= alu_res;
          if (op == OP_BEQ)   pc <= (ra_data == rb_data) ? br_target : pc_inc;
          if (op == OP_JMP)   pc <= ir[PC_W-1:0];
        end
        S_MEM: begin
          if (mem_done) begin
            mdr <= dmem_rdata;
            if (op == OP_STORE) pc <= pc_inc;
          end
        end
        S_WB:    pc <= pc_inc;
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc;
  assign dmem_req   = (state == S_MEM);
  assign dmem_we    = (op == OP_STORE);
  assign dmem_addr  = ir[MADDR_MSB:0];
  assign dmem_wdata = ra_data;
  assign halted     = (state == S_HALT);

endmodule
